// File: rtl/titan_mem_arbiter.sv
// titan_mem_arbiter: shares one memory bus between the fetch port (iport) and
// the data port (dport). One transaction at a time; data wins ties, except when
// fetch has already waited STARVE_LIMIT data grants. A bus timeout turns a hung
// access into an error response so neither pipeline port can deadlock.
module titan_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        iport_valid,
    input  logic [31:0] iport_addr,
    output logic        iport_ready,
    output logic [31:0] iport_rdata,
    output logic        iport_error,

    input  logic        dport_valid,
    input  logic [31:0] dport_addr,
    input  logic [31:0] dport_wdata,
    input  logic [3:0]  dport_wr_en,
    output logic        dport_ready,
    output logic [31:0] dport_rdata,
    output logic        dport_error,

    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wr_en,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error
);

    localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT - 1);
    localparam bit            TO_EN      = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {GNT_I, GNT_D} gnt_t;

    state_t        state;
    gnt_t          gnt;
    logic [SW-1:0] starve_cnt;
    logic [7:0]    to_cnt;

    logic grant_d;
    logic timeout_hit;

    // Data wins unless fetch is waiting and has hit its starvation bound.
    always_comb begin
        grant_d     = dport_valid && !(iport_valid && (starve_cnt == STARVE_MAX));
        timeout_hit = TO_EN && (to_cnt == TO_LAST);
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= GNT_I;
            starve_cnt  <= '0;
            to_cnt      <= '0;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wr_en   <= '0;
            iport_ready <= 1'b0;
            iport_rdata <= '0;
            iport_error <= 1'b0;
            dport_ready <= 1'b0;
            dport_rdata <= '0;
            dport_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        gnt       <= GNT_D;
                        mem_valid <= 1'b1;
                        mem_addr  <= dport_addr;
                        mem_wdata <= dport_wdata;
                        mem_wr_en <= dport_wr_en;
                        to_cnt    <= '0;
                        state     <= BUSY;
                        // Only count data grants that actually made fetch wait.
                        if (!iport_valid) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (iport_valid) begin
                        gnt        <= GNT_I;
                        mem_valid  <= 1'b1;
                        mem_addr   <= iport_addr;
                        mem_wdata  <= '0;
                        mem_wr_en  <= '0;
                        to_cnt     <= '0;
                        starve_cnt <= '0;
                        state      <= BUSY;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                BUSY: begin
                    to_cnt <= to_cnt + 8'd1;
                    // A real completion beats a coincident timeout.
                    if (mem_ready || timeout_hit) begin
                        mem_valid <= 1'b0;
                        state     <= RESP;
                        if (gnt == GNT_D) begin
                            dport_ready <= 1'b1;
                            dport_rdata <= mem_ready ? mem_rdata : 32'd0;
                            dport_error <= mem_ready ? mem_error : 1'b1;
                        end else begin
                            iport_ready <= 1'b1;
                            iport_rdata <= mem_ready ? mem_rdata : 32'd0;
                            iport_error <= mem_ready ? mem_error : 1'b1;
                        end
                    end
                end
                RESP: begin
                    // No arbitration here: the requester's valid is still high.
                    iport_ready <= 1'b0;
                    dport_ready <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_titan_mem_arbiter.sv
// Randomized scoreboard bench for titan_mem_arbiter. A transaction-level model
// decides each grant and its outcome from cycle numbers; monitors compare the
// bus and the response strobes against queued expectations.
module tb_titan_mem_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned TO    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iport_valid, iport_ready, iport_error;
    logic [31:0] iport_addr, iport_rdata;
    logic        dport_valid, dport_ready, dport_error;
    logic [31:0] dport_addr, dport_wdata, dport_rdata;
    logic [3:0]  dport_wr_en;
    logic        mem_valid, mem_ready, mem_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wr_en;

    titan_mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .iport_valid(iport_valid), .iport_addr(iport_addr), .iport_ready(iport_ready),
        .iport_rdata(iport_rdata), .iport_error(iport_error),
        .dport_valid(dport_valid), .dport_addr(dport_addr), .dport_wdata(dport_wdata),
        .dport_wr_en(dport_wr_en), .dport_ready(dport_ready), .dport_rdata(dport_rdata),
        .dport_error(dport_error),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr_en(mem_wr_en), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_d; logic [31:0] rdata; logic err; int at; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wr_en;
                     int first; int last; } bus_t;
    typedef struct { int at; logic [31:0] rdata; logic err; } plan_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    plan_t plan_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit run = 1'b0;
    int free_at = 0;
    int starve = 0;
    int d_grants = 0;
    int i_grants = 0;
    logic [31:0] hold_i_rdata = '0, hold_d_rdata = '0;
    logic        hold_i_err = 1'b0, hold_d_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_valid"},   32'(mem_valid),   32'd0);
        check({tag, "_mem_addr"},    mem_addr,         32'd0);
        check({tag, "_mem_wdata"},   mem_wdata,        32'd0);
        check({tag, "_mem_wr_en"},   32'(mem_wr_en),   32'd0);
        check({tag, "_iport_ready"}, 32'(iport_ready), 32'd0);
        check({tag, "_iport_rdata"}, iport_rdata,      32'd0);
        check({tag, "_iport_error"}, 32'(iport_error), 32'd0);
        check({tag, "_dport_ready"}, 32'(dport_ready), 32'd0);
        check({tag, "_dport_rdata"}, dport_rdata,      32'd0);
        check({tag, "_dport_error"}, 32'(dport_error), 32'd0);
    endtask

    // Reference model: an interval ends at each posedge; cyc names that interval.
    // A grant in interval c with memory answering after d cycles yields the
    // response in interval c+min(d,TO)+1 and frees the arbiter one interval later.
    initial begin : model
        bit          take_d;
        int          d, span, sel;
        logic [31:0] rd;
        logic        er;
        resp_t       r;
        bus_t        b;
        plan_t       p;
        forever begin
            @(posedge clk);
            if (rst) begin
                starve  = 0;
                free_at = cyc + 1;
            end else if (cyc >= free_at && (iport_valid || dport_valid)) begin
                take_d = dport_valid && !(iport_valid && starve >= int'(LIMIT));
                if (take_d && iport_valid) starve = starve + 1;
                else starve = 0;
                if (take_d) d_grants++;
                else i_grants++;
                sel = int'($urandom % 16);
                if (sel < 8) d = 1 + int'($urandom % 3);
                else if (sel < 10) d = 6;
                else if (sel == 10) d = int'(TO);
                else if (sel == 11) d = int'(TO) + 1;
                else if (sel == 12) d = int'(TO) + 2;
                else if (sel == 13) d = 1000;
                else d = 1;
                span = (d < int'(TO)) ? d : int'(TO);
                rd = $urandom;
                er = ($urandom % 4) == 0;
                b.addr  = take_d ? dport_addr : iport_addr;
                b.wdata = take_d ? dport_wdata : 32'd0;
                b.wr_en = take_d ? dport_wr_en : 4'd0;
                b.first = cyc + 1;
                b.last  = cyc + span;
                bus_q.push_back(b);
                if (d != 1000) begin
                    p.at = cyc + d; p.rdata = rd; p.err = er;
                    plan_q.push_back(p);
                end
                r.is_d  = take_d;
                r.rdata = (d <= int'(TO)) ? rd : 32'd0;
                r.err   = (d <= int'(TO)) ? er : 1'b1;
                r.at    = cyc + span + 1;
                resp_q.push_back(r);
                free_at = cyc + span + 2;
            end else if (cyc >= free_at) begin
                starve = 0;
            end
            cyc++;
        end
    end

    // Memory side: answer on the planned interval, drive junk otherwise.
    initial begin : mem_side
        mem_ready = 1'b0; mem_rdata = '0; mem_error = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            mem_error = 1'($urandom % 2);
            while (plan_q.size() != 0 && plan_q[0].at < cyc) void'(plan_q.pop_front());
            if (plan_q.size() != 0 && plan_q[0].at == cyc) begin
                mem_ready = 1'b1;
                mem_rdata = plan_q[0].rdata;
                mem_error = plan_q[0].err;
                void'(plan_q.pop_front());
            end
        end
    end

    // Fetch requester: holds its request until ready, changes it one cycle later.
    initial begin : ip_drv
        bit after;
        after = 1'b0; iport_valid = 1'b0; iport_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                iport_valid = 1'b0; after = 1'b0;
            end else if (after) begin
                after = 1'b0;
                if (run && ($urandom % 4) != 0) begin
                    iport_valid = 1'b1; iport_addr = $urandom;
                end else iport_valid = 1'b0;
            end else if (iport_valid && iport_ready) begin
                after = 1'b1;
            end else if (!iport_valid && run && ($urandom % 3) == 0) begin
                iport_valid = 1'b1; iport_addr = $urandom;
            end
        end
    end

    // Data requester: same protocol, with random reads and byte-enable writes.
    initial begin : dp_drv
        bit after;
        after = 1'b0; dport_valid = 1'b0; dport_addr = '0; dport_wdata = '0; dport_wr_en = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                dport_valid = 1'b0; after = 1'b0;
            end else if (after) begin
                after = 1'b0;
                if (run && ($urandom % 4) != 0) begin
                    dport_valid = 1'b1; dport_addr = $urandom; dport_wdata = $urandom;
                    dport_wr_en = ($urandom % 2) != 0 ? 4'($urandom) : 4'd0;
                end else dport_valid = 1'b0;
            end else if (dport_valid && dport_ready) begin
                after = 1'b1;
            end else if (!dport_valid && run && ($urandom % 3) == 0) begin
                dport_valid = 1'b1; dport_addr = $urandom; dport_wdata = $urandom;
                dport_wr_en = ($urandom % 2) != 0 ? 4'($urandom) : 4'd0;
            end
        end
    end

    // Bus monitor: mem_valid exactly over each expected window, fields stable.
    initial begin : bus_mon
        forever begin
            @(posedge clk); #1;
            while (bus_q.size() != 0 && bus_q[0].last < cyc) void'(bus_q.pop_front());
            if (bus_q.size() != 0 && bus_q[0].first <= cyc) begin
                check("mem_valid_busy", 32'(mem_valid), 32'd1);
                check("mem_addr", mem_addr, bus_q[0].addr);
                check("mem_wdata", mem_wdata, bus_q[0].wdata);
                check("mem_wr_en", 32'(mem_wr_en), 32'(bus_q[0].wr_en));
            end else begin
                check("mem_valid_idle", 32'(mem_valid), 32'd0);
            end
        end
    end

    // Response monitor: pops an expectation whenever a ready strobe appears.
    initial begin : resp_mon
        resp_t e;
        forever begin
            @(posedge clk); #1;
            if (iport_ready || dport_ready) begin
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready cycle %0d: iport_ready %b dport_ready %b required none",
                             cyc, iport_ready, dport_ready);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_cycle", 32'(cyc), 32'(e.at));
                    check("resp_dport_ready", 32'(dport_ready), 32'(e.is_d));
                    check("resp_iport_ready", 32'(iport_ready), 32'(!e.is_d));
                    if (e.is_d) begin
                        hold_d_rdata = e.rdata; hold_d_err = e.err;
                    end else begin
                        hold_i_rdata = e.rdata; hold_i_err = e.err;
                    end
                    check("dport_rdata", dport_rdata, hold_d_rdata);
                    check("dport_error", 32'(dport_error), 32'(hold_d_err));
                    check("iport_rdata", iport_rdata, hold_i_rdata);
                    check("iport_error", 32'(iport_error), 32'(hold_i_err));
                end
            end else if (resp_q.size() != 0 && resp_q[0].at <= cyc) begin
                checks++; errors++;
                $display("FAIL missing_ready cycle %0d: got no ready required ready at cycle %0d",
                         cyc, resp_q[0].at);
                void'(resp_q.pop_front());
            end
        end
    end

    initial begin : main
        int quiet_ready;
        int n;
        repeat (2) @(posedge clk);
        #2 check_all_zero("reset");
        @(negedge clk) rst = 1'b0;
        run = 1'b1;
        repeat (1500) @(posedge clk);

        // Reset between edges while a transaction is on the bus.
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (mem_valid) break;
            @(negedge clk);
        end
        check("busy_before_reset", 32'(mem_valid), 32'd1);
        #2;
        rst = 1'b1;
        run = 1'b0;
        resp_q.delete(); bus_q.delete(); plan_q.delete();
        hold_i_rdata = '0; hold_d_rdata = '0; hold_i_err = 1'b0; hold_d_err = 1'b0;
        #1 check_all_zero("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        quiet_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (iport_ready || dport_ready) quiet_ready++;
        end
        check("no_ready_after_reset", 32'(quiet_ready), 32'd0);

        run = 1'b1;
        repeat (1500) @(posedge clk);
        run = 1'b0;
        n = 0;
        while (n < 200 && (resp_q.size() != 0 || iport_valid || dport_valid)) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check("drained", 32'(resp_q.size()), 32'd0);
        check("fetch_granted", 32'(i_grants > 0), 32'd1);
        check("data_granted", 32'(d_grants > 0), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
